// File: rtl/booth_seq_multiplier_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | booth_seq_multiplier_if : operand/result valid-ready bundle  (rev 1.0)   |
// +--------------------------------------------------------------------------+
interface booth_seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               busy;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/booth_seq_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | booth_seq_multiplier : iterative radix-2/4 Booth multiplier   (rev 1.0)  |
// +--------------------------------------------------------------------------+
module booth_seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int RADIX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  booth_seq_multiplier_if.slave  bus
);

  localparam int EW    = WIDTH + 2;
  localparam int ACC_W = 2 * EW + 1;
  localparam int ITER  = (RADIX == 2) ? EW : EW / 2;
  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  generate
    if (RADIX != 2 && RADIX != 4) begin : g_bad_radix
      $error("booth_seq_multiplier: RADIX must be 2 or 4");
    end
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_seq_multiplier: WIDTH must be even and >= 4");
    end
  endgenerate

  logic [1:0]         state_q,  state_d;
  logic [ACC_W-1:0]   acc_q,    acc_d;
  logic [EW-1:0]      m_q,      m_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [ACC_W-1:0]   acc_step;
  logic [EW-1:0]      a_ext;
  logic [EW-1:0]      b_ext;

  assign a_ext = bus.is_signed ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
  assign b_ext = bus.is_signed ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};

  // Accumulator layout: {partial product (EW), remaining multiplier (EW), guard}.
  generate
    if (RADIX == 2) begin : g_radix2
      logic [EW:0] hi_x;
      logic [EW:0] m1;
      logic [EW:0] sum;

      assign hi_x = {acc_q[ACC_W-1], acc_q[ACC_W-1:EW+1]};
      assign m1   = {m_q[EW-1], m_q};

      always_comb begin
        sum = hi_x;
        case (acc_q[1:0])
          2'b01:   sum = hi_x + m1;
          2'b10:   sum = hi_x - m1;
          default: sum = hi_x;
        endcase
      end

      assign acc_step = {sum, acc_q[EW:1]};
    end else begin : g_radix4
      logic [EW+1:0] hi_x;
      logic [EW+1:0] m1;
      logic [EW+1:0] m2;
      logic [EW+1:0] sum;

      // Two spare high bits keep hi +/- 2M from overflowing before the shift.
      assign hi_x = {{2{acc_q[ACC_W-1]}}, acc_q[ACC_W-1:EW+1]};
      assign m1   = {{2{m_q[EW-1]}}, m_q};
      assign m2   = {m_q[EW-1], m_q, 1'b0};

      always_comb begin
        sum = hi_x;
        case (acc_q[2:0])
          3'b001, 3'b010: sum = hi_x + m1;
          3'b011:         sum = hi_x + m2;
          3'b100:         sum = hi_x - m2;
          3'b101, 3'b110: sum = hi_x - m1;
          default:        sum = hi_x;
        endcase
      end

      assign acc_step = {sum, acc_q[EW:2]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          m_d     = a_ext;
          acc_d   = {{EW{1'b0}}, b_ext, 1'b0};
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          result_d = acc_step[2*WIDTH:1];
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_booth_seq_multiplier : directed vectors for both radix configs (1.0)  |
// +--------------------------------------------------------------------------+
module tb_booth_seq_multiplier;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  booth_seq_multiplier_if #(.WIDTH(32)) bus32 ();
  booth_seq_multiplier_if #(.WIDTH(8))  bus8 ();

  booth_seq_multiplier #(.WIDTH(32), .RADIX(4)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32.slave)
  );

  booth_seq_multiplier #(.WIDTH(8), .RADIX(2)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic issue32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    check({tag, "_in_ready"}, 64'(bus32.in_ready), 64'd1);
    bus32.a = a; bus32.b = b; bus32.is_signed = s; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid  = 1'b0;
    bus32.a         = $urandom;
    bus32.b         = $urandom;
    bus32.is_signed = ~s;
  endtask

  task automatic wait_out32(input string tag, input int exp_lat);
    int cyc = 0;
    while (!bus32.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
  endtask

  task automatic retire32(input string tag);
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
    check({tag, "_ready_after"}, 64'(bus32.in_ready), 64'd1);
  endtask

  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp);
    issue32(tag, a, b, s);
    wait_out32(tag, 17);
    check(tag, bus32.result, exp);
    retire32(tag);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [15:0] exp);
    int cyc = 0;
    bus8.a = a; bus8.b = b; bus8.is_signed = s; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.a = 8'h5A; bus8.b = 8'hA5;
    while (!bus8.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd10);
    check(tag, 64'(bus8.result), 64'(exp));
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    check({tag, "_ready_after"}, 64'(bus8.in_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b0;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
    bus32.a = '0; bus32.b = '0; bus32.is_signed = 1'b0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.is_signed = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_result",    bus32.result,           64'd0);
    check("rst_out_valid", 64'(bus32.out_valid),   64'd0);
    check("rst_busy",      64'(bus32.busy),        64'd0);
    check("rst_in_ready",  64'(bus32.in_ready),    64'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    run32("s5xm7",     32'd5,        32'hFFFF_FFF9, 1'b1, 64'hFFFF_FFFF_FFFF_FFDD);
    run32("u_ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run32("s_ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    run32("s_minneg",  32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    run32("zero",      32'd11,       32'd0,         1'b1, 64'd0);
    run32("sm9x5",     32'hFFFF_FFF7, 32'd5,        1'b1, 64'hFFFF_FFFF_FFFF_FFD3);

    // Backpressure: result held, extra in_valid ignored while DONE.
    issue32("bp", 32'd2, 32'd3, 1'b0);
    wait_out32("bp", 17);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus32.a = 32'd4; bus32.b = 32'd6; bus32.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus32.in_valid = 1'b0;
      check("bp_hold_result", bus32.result,          64'd6);
      check("bp_hold_ready",  64'(bus32.in_ready),   64'd0);
      check("bp_hold_valid",  64'(bus32.out_valid),  64'd1);
    end
    retire32("bp");
    check("bp_no_queue", 64'(bus32.busy), 64'd0);
    run32("s4x6", 32'd4, 32'd6, 1'b0, 64'd24);

    // Reset in the middle of a calculation aborts it.
    issue32("abort", 32'hFFFF_FFF4, 32'hFFFF_FFFC, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    check("abort_busy_pre", 64'(bus32.busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_out_valid", 64'(bus32.out_valid), 64'd0);
    check("abort_result",    bus32.result,         64'd0);
    check("abort_busy",      64'(bus32.busy),      64'd0);
    check("abort_in_ready",  64'(bus32.in_ready),  64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run32("s10x1", 32'd10, 32'd1, 1'b1, 64'd10);

    run8("w8_sm12xm4", 8'hF4, 8'hFC, 1'b1, 16'h0030);
    run8("w8_uF4xFC",  8'hF4, 8'hFC, 1'b0, 16'hF030);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
